decode_stage: RTL and testbench

- Pipelined RISC-V RV32I instruction decode stage.
- Accepts a 32-bit instruction and its PC from fetch over a valid/ready handshake.
- Registers the decoded fields (ALUOp/Funct3/Funct7 for alucontroller, register addresses, immediate, control strobes) toward execute.
- Acts as the producer side of the ALUOp/Funct3/Funct7 interface that alucontroller consumes.

---
 rtl/decode_stage.sv | 189 ++++++++++++++++++
 tb/tb_decode_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: single-entry pipeline register between fetch and execute.
// Produces the ALUOp/Funct3/Funct7 bundle consumed by alucontroller.
module decode_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [DATA_WIDTH-1:0] in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [2:0]            ALUOp,
  output logic [2:0]            Funct3,
  output logic [6:0]            Funct7,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  output logic [4:0]            rd,
  output logic [DATA_WIDTH-1:0] imm,
  output logic                  alu_src_imm,
  output logic                  reg_write,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  branch,
  output logic                  jump,
  output logic                  illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] ALU_ADD    = 3'd0;
  localparam logic [2:0] ALU_BRANCH = 3'd1;
  localparam logic [2:0] ALU_RTYPE  = 3'd2;
  localparam logic [2:0] ALU_ITYPE  = 3'd3;
  localparam logic [2:0] ALU_PASS   = 3'd4;

  logic                  load;
  logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  logic [2:0]            aluop_next;
  logic [6:0]            funct7_next;
  logic [4:0]            rs2_next;
  logic [DATA_WIDTH-1:0] imm_next;
  logic                  alu_src_imm_next;
  logic                  reg_write_next;
  logic                  mem_read_next;
  logic                  mem_write_next;
  logic                  branch_next;
  logic                  jump_next;
  logic                  illegal_next;

  assign in_ready = !out_valid || out_ready;
  assign load     = in_valid && in_ready && !flush;

  // Bit 31 is the sign bit of every immediate format.
  assign imm_i = {{(DATA_WIDTH-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{(DATA_WIDTH-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{(DATA_WIDTH-12){in_instr[31]}}, in_instr[7], in_instr[30:25],
                  in_instr[11:8], 1'b0};
  assign imm_u = {{(DATA_WIDTH-31){in_instr[31]}}, in_instr[30:12], 12'b0};
  assign imm_j = {{(DATA_WIDTH-20){in_instr[31]}}, in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};

  always_comb begin
    aluop_next       = ALU_ADD;
    funct7_next      = '0;
    rs2_next         = '0;
    imm_next         = '0;
    alu_src_imm_next = 1'b0;
    reg_write_next   = 1'b0;
    mem_read_next    = 1'b0;
    mem_write_next   = 1'b0;
    branch_next      = 1'b0;
    jump_next        = 1'b0;
    illegal_next     = 1'b0;
    case (in_instr[6:0])
      OPC_OP: begin
        aluop_next     = ALU_RTYPE;
        funct7_next    = in_instr[31:25];
        rs2_next       = in_instr[24:20];
        reg_write_next = 1'b1;
      end
      OPC_OP_IMM: begin
        // funct7 stays visible so SRAI can be told apart from SRLI
        aluop_next       = ALU_ITYPE;
        funct7_next      = in_instr[31:25];
        imm_next         = imm_i;
        alu_src_imm_next = 1'b1;
        reg_write_next   = 1'b1;
      end
      OPC_LOAD: begin
        imm_next         = imm_i;
        alu_src_imm_next = 1'b1;
        mem_read_next    = 1'b1;
        reg_write_next   = 1'b1;
      end
      OPC_STORE: begin
        rs2_next         = in_instr[24:20];
        imm_next         = imm_s;
        alu_src_imm_next = 1'b1;
        mem_write_next   = 1'b1;
      end
      OPC_BRANCH: begin
        aluop_next  = ALU_BRANCH;
        rs2_next    = in_instr[24:20];
        imm_next    = imm_b;
        branch_next = 1'b1;
      end
      OPC_JAL: begin
        imm_next       = imm_j;
        jump_next      = 1'b1;
        reg_write_next = 1'b1;
      end
      OPC_JALR: begin
        imm_next         = imm_i;
        alu_src_imm_next = 1'b1;
        jump_next        = 1'b1;
        reg_write_next   = 1'b1;
      end
      OPC_LUI: begin
        aluop_next       = ALU_PASS;
        imm_next         = imm_u;
        alu_src_imm_next = 1'b1;
        reg_write_next   = 1'b1;
      end
      OPC_AUIPC: begin
        imm_next         = imm_u;
        alu_src_imm_next = 1'b1;
        reg_write_next   = 1'b1;
      end
      default: illegal_next = 1'b1;
    endcase
    if (in_instr[11:7] == 5'd0) reg_write_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      ALUOp       <= '0;
      Funct3      <= '0;
      Funct7      <= '0;
      rs1         <= '0;
      rs2         <= '0;
      rd          <= '0;
      imm         <= '0;
      alu_src_imm <= 1'b0;
      reg_write   <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      branch      <= 1'b0;
      jump        <= 1'b0;
      illegal     <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      ALUOp       <= aluop_next;
      Funct3      <= in_instr[14:12];
      Funct7      <= funct7_next;
      rs1         <= in_instr[19:15];
      rs2         <= rs2_next;
      rd          <= in_instr[11:7];
      imm         <= imm_next;
      alu_src_imm <= alu_src_imm_next;
      reg_write   <= reg_write_next;
      mem_read    <= mem_read_next;
      mem_write   <= mem_write_next;
      branch      <= branch_next;
      jump        <= jump_next;
      illegal     <= illegal_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed RV32I words with hand-computed bundles.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc;
  logic [2:0]  ALUOp;
  logic [2:0]  Funct3;
  logic [6:0]  Funct7;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic        alu_src_imm, reg_write, mem_read, mem_write, branch, jump, illegal;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  aluop;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        src;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic        jp;
    logic        ill;
  } bundle_t;

  bundle_t act;
  bundle_t exp_q[$];
  bundle_t vec_exp[12];
  logic [31:0] vec_instr[12];
  int checks = 0;
  int failures = 0;

  decode_stage #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .ALUOp(ALUOp), .Funct3(Funct3), .Funct7(Funct7),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .alu_src_imm(alu_src_imm), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch), .jump(jump), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign act = {out_pc, ALUOp, Funct3, Funct7, rs1, rs2, rd, imm,
                alu_src_imm, reg_write, mem_read, mem_write, branch, jump, illegal};

  function automatic bundle_t mk(
    input logic [31:0] pc, input logic [2:0] aluop, input logic [2:0] f3,
    input logic [6:0] f7, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdd,
    input logic [31:0] im, input logic src, input logic rw, input logic mr,
    input logic mw, input logic br, input logic jp, input logic ill);
    mk = {pc, aluop, f3, f7, r1, r2, rdd, im, src, rw, mr, mw, br, jp, ill};
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, want);
    end else begin
      $display("ok   %s = %0h", name, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pops one expected bundle for every accepted output beat.
  task automatic monitor();
    bundle_t e;
    forever begin
      @(negedge clk);
      if (!rst && !flush && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_bundle got=%0h exp=none", act);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("bundle_pc%0h", e.pc), act, e);
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    //                      pc        alu f3 f7     rs1 rs2 rd  imm           src rw mr mw br jp ill
    vec_instr[0]  = 32'h002081B3; vec_exp[0]  = mk(32'h100, 2, 0, 7'h00, 1, 2, 3,  32'h00000000, 0, 1, 0, 0, 0, 0, 0);
    vec_instr[1]  = 32'hFFF00093; vec_exp[1]  = mk(32'h104, 3, 0, 7'h7F, 0, 0, 1,  32'hFFFFFFFF, 1, 1, 0, 0, 0, 0, 0);
    vec_instr[2]  = 32'h0020A423; vec_exp[2]  = mk(32'h108, 0, 2, 7'h00, 1, 2, 8,  32'h00000008, 1, 0, 0, 1, 0, 0, 0);
    vec_instr[3]  = 32'hFE000EE3; vec_exp[3]  = mk(32'h10C, 1, 0, 7'h00, 0, 0, 29, 32'hFFFFFFFC, 0, 0, 0, 0, 1, 0, 0);
    vec_instr[4]  = 32'h123452B7; vec_exp[4]  = mk(32'h110, 4, 5, 7'h00, 8, 0, 5,  32'h12345000, 1, 1, 0, 0, 0, 0, 0);
    vec_instr[5]  = 32'h00000000; vec_exp[5]  = mk(32'h114, 0, 0, 7'h00, 0, 0, 0,  32'h00000000, 0, 0, 0, 0, 0, 0, 1);
    vec_instr[6]  = 32'h40335293; vec_exp[6]  = mk(32'h118, 3, 5, 7'h20, 6, 0, 5,  32'h00000403, 1, 1, 0, 0, 0, 0, 0);
    vec_instr[7]  = 32'h00000013; vec_exp[7]  = mk(32'h11C, 3, 0, 7'h00, 0, 0, 0,  32'h00000000, 1, 0, 0, 0, 0, 0, 0);
    vec_instr[8]  = 32'hFF812203; vec_exp[8]  = mk(32'h120, 0, 2, 7'h00, 2, 0, 4,  32'hFFFFFFF8, 1, 1, 1, 0, 0, 0, 0);
    vec_instr[9]  = 32'h008000EF; vec_exp[9]  = mk(32'h124, 0, 0, 7'h00, 0, 0, 1,  32'h00000008, 0, 1, 0, 0, 0, 1, 0);
    vec_instr[10] = 32'h004280E7; vec_exp[10] = mk(32'h128, 0, 0, 7'h00, 5, 0, 1,  32'h00000004, 1, 1, 0, 0, 0, 1, 0);
    vec_instr[11] = 32'hFFFFF397; vec_exp[11] = mk(32'h12C, 0, 7, 7'h00, 31, 0, 7, 32'hFFFFF000, 1, 1, 0, 0, 0, 0, 0);

    fork
      monitor();
    join_none

    // reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_bundle", act, '0);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);

    // single directed instructions
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("in_ready_vec%0d", i), in_ready, 1'b1);
      in_valid = 1'b1;
      in_instr = vec_instr[i];
      in_pc    = vec_exp[i].pc;
      exp_q.push_back(vec_exp[i]);
      step();
      in_valid = 1'b0;
      chk($sformatf("latency_vec%0d", i), out_valid, 1'b1);
      step();
    end

    // backpressure: add held while addi waits
    in_valid = 1'b1;
    in_instr = vec_instr[0];
    in_pc    = vec_exp[0].pc;
    exp_q.push_back(vec_exp[0]);
    step();
    out_ready = 1'b0;
    in_instr  = vec_instr[1];
    in_pc     = vec_exp[1].pc;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stall_in_ready%0d", k), in_ready, 1'b0);
      chk($sformatf("stall_hold%0d", k), act, vec_exp[0]);
    end
    step();
    out_ready = 1'b1;
    exp_q.push_back(vec_exp[1]);
    step();
    in_valid = 1'b0;
    chk("release_out_valid", out_valid, 1'b1);
    step();
    step();

    // back-to-back full throughput
    for (int i = 8; i < 12; i++) begin
      in_valid = 1'b1;
      in_instr = vec_instr[i];
      in_pc    = vec_exp[i].pc;
      exp_q.push_back(vec_exp[i]);
      step();
      chk($sformatf("b2b_valid%0d", i - 8), out_valid, 1'b1);
    end
    in_valid = 1'b0;
    step();
    step();

    // flush discards both the held bundle and the concurrent input
    in_valid = 1'b1;
    in_instr = vec_instr[2];
    in_pc    = vec_exp[2].pc;
    exp_q.push_back(vec_exp[2]);
    step();
    flush    = 1'b1;
    in_instr = vec_instr[4];
    in_pc    = vec_exp[4].pc;
    void'(exp_q.pop_back());
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 1'b0);
    step();
    step();

    // reset during a stall, racing a new input
    in_valid = 1'b1;
    in_instr = vec_instr[0];
    in_pc    = vec_exp[0].pc;
    exp_q.push_back(vec_exp[0]);
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    step();
    rst       = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = vec_instr[4];
    in_pc     = vec_exp[4].pc;
    void'(exp_q.pop_back());
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_imm", imm, 32'h0);
    chk("rst_aluop", ALUOp, 3'd0);
    chk("rst_bundle", act, '0);
    step();
    step();

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
